// File: rtl/downcounter_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package downcounter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/downcounter_timer_dffr_vec.sv
// Vector register with synchronous active-high reset and load enable.
module dffr_vec #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/downcounter_timer.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and optional auto-reload.
//   state | meaning
//   IDLE  | count holds, en ignored
//   RUN   | counting down on enabled cycles
module downcounter_timer
  import downcounter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q;
  logic             count_en;
  logic             reload_en;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  dffr_vec #(.WIDTH(WIDTH)) u_count (
    .clk (clk),
    .rst (rst),
    .en  (count_en),
    .d   (count_d),
    .q   (count_q)
  );

  dffr_vec #(.WIDTH(WIDTH)) u_reload (
    .clk (clk),
    .rst (rst),
    .en  (reload_en),
    .d   (load_val),
    .q   (reload_q)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    count_en  = 1'b0;
    reload_en = 1'b0;
    tc_d      = 1'b0;

    if (load) begin
      count_d   = load_val;
      count_en  = 1'b1;
      reload_en = 1'b1;
      if (load_val == '0) begin
        state_d = IDLE;
        tc_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN && en) begin
      if (count_q > ONE) begin
        count_d  = count_q - ONE;
        count_en = 1'b1;
      end else if (count_q == ONE) begin
        count_d  = '0;
        count_en = 1'b1;
        tc_d     = 1'b1;
        if (!auto_reload) begin
          state_d = IDLE;
        end
      end else if (auto_reload) begin
        // Wrap point of the periodic sequence: reload instead of underflowing.
        count_d  = reload_q;
        count_en = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_downcounter_timer.sv
// Directed scenarios plus randomized traffic checked against a behavioural timer model.
module tb_downcounter_timer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the timer's visible state.
  int m_count  = 0;
  int m_reload = 0;
  bit m_run    = 1'b0;
  bit m_tc     = 1'b0;

  downcounter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc          (tc)
  );

  always #5 clk = ~clk;

  // Apply inputs, advance one clock edge, update the model, sample 1 ns later.
  task automatic step(input bit r, input bit ld, input int lv, input bit e, input bit ar);
    rst = r; load = ld; load_val = W'(lv); en = e; auto_reload = ar;
    @(posedge clk);
    if (r) begin
      m_count = 0; m_reload = 0; m_run = 0; m_tc = 0;
    end else if (ld) begin
      m_count = lv; m_reload = lv; m_run = (lv != 0); m_tc = (lv == 0);
    end else begin
      m_tc = 0;
      if (m_run && e) begin
        if (m_count == 0) begin
          if (ar) m_count = m_reload;
          else    m_run = 0;
        end else begin
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_tc = 1;
            if (!ar) m_run = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    checks++;
    if (count !== 3'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: count=%0d busy=%0b tc=%0b, want 0/0/0", count, busy, tc);
    end
    step(0, 1, 6, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (count !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prep: count=%0d busy=%0b, want 4/1", count, busy);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 7, 1, 1);
      checks++;
      if (count !== 3'd0 || busy !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_run[%0d]: count=%0d busy=%0b tc=%0b, want 0/0/0", i, count, busy, tc);
      end
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (count !== 3'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_en: count=%0d busy=%0b tc=%0b, want 0/0/0", count, busy, tc);
    end
  endtask

  task automatic test_one_shot();
    int exp_seq[5] = '{4, 3, 2, 1, 0};
    step(0, 1, 5, 1, 0);
    checks++;
    if (count !== 3'd5 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_load: count=%0d busy=%0b tc=%0b, want 5/1/0", count, busy, tc);
    end
    foreach (exp_seq[i]) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (count !== W'(exp_seq[i]) || tc !== (exp_seq[i] == 0) || busy !== (exp_seq[i] != 0)) begin
        errors++;
        $display("FAIL one_shot_seq[%0d]: count=%0d tc=%0b busy=%0b, want %0d/%0b/%0b",
                 i, count, tc, busy, exp_seq[i], exp_seq[i] == 0, exp_seq[i] != 0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (count !== 3'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL one_shot_after[%0d]: count=%0d tc=%0b busy=%0b, want 0/0/0", i, count, tc, busy);
      end
    end
  endtask

  task automatic test_periodic();
    int exp_seq[7] = '{1, 0, 2, 1, 0, 2, 1};
    step(0, 1, 2, 1, 1);
    checks++;
    if (count !== 3'd2 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL periodic_load: count=%0d busy=%0b tc=%0b, want 2/1/0", count, busy, tc);
    end
    foreach (exp_seq[i]) begin
      step(0, 0, 0, 1, 1);
      checks++;
      if (count !== W'(exp_seq[i]) || tc !== (exp_seq[i] == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL periodic_seq[%0d]: count=%0d tc=%0b busy=%0b, want %0d/%0b/1",
                 i, count, tc, busy, exp_seq[i], exp_seq[i] == 0);
      end
    end
  endtask

  task automatic test_enable_gating();
    bit en_seq[5]  = '{1, 0, 0, 1, 1};
    int exp_seq[5] = '{2, 2, 2, 1, 0};
    step(0, 1, 3, 1, 0);
    checks++;
    if (count !== 3'd3 || tc !== 1'b0) begin
      errors++;
      $display("FAIL gating_load: count=%0d tc=%0b, want 3/0", count, tc);
    end
    foreach (en_seq[i]) begin
      step(0, 0, 0, en_seq[i], 0);
      checks++;
      if (count !== W'(exp_seq[i]) || tc !== (i == 4)) begin
        errors++;
        $display("FAIL gating_seq[%0d]: count=%0d tc=%0b, want %0d/%0b", i, count, tc, exp_seq[i], i == 4);
      end
    end
  endtask

  task automatic test_restart_collision();
    step(0, 1, 2, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (count !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_prep: count=%0d busy=%0b, want 1/1", count, busy);
    end
    step(0, 1, 7, 1, 0);
    checks++;
    if (count !== 3'd7 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_collision: count=%0d tc=%0b busy=%0b, want 7/0/1", count, tc, busy);
    end
    for (int v = 6; v >= 0; v--) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (count !== W'(v) || tc !== (v == 0) || busy !== (v != 0)) begin
        errors++;
        $display("FAIL restart_max_seq[%0d]: count=%0d tc=%0b busy=%0b, want %0d/%0b/%0b",
                 v, count, tc, busy, v, v == 0, v != 0);
      end
    end
  endtask

  task automatic test_zero_load_mode_switch();
    step(0, 1, 3, 1, 0);
    step(0, 1, 0, 1, 0);
    checks++;
    if (count !== 3'd0 || tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_load: count=%0d tc=%0b busy=%0b, want 0/1/0", count, tc, busy);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_load_after: tc=%0b busy=%0b, want 0/0", tc, busy);
    end
    step(0, 1, 3, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    checks++;
    if (count !== 3'd0 || tc !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mode_switch_zero: count=%0d tc=%0b busy=%0b, want 0/1/1", count, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (count !== 3'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mode_switch_idle[%0d]: count=%0d tc=%0b busy=%0b, want 0/0/0", i, count, tc, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0));
      checks++;
      if (count !== W'(m_count) || busy !== m_run || tc !== m_tc) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d busy=%0b tc=%0b, want %0d/%0b/%0b",
                 i, count, busy, tc, m_count, m_run, m_tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_gating();
    test_restart_collision();
    test_zero_load_mode_switch();
    step(1, 0, 0, 0, 0);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/downcounter_timer.md
# downcounter_timer

Loadable down-counter/timer: the counting-down counterpart of the team's 3-bit up-counter family. It loads a start value, decrements on each enabled cycle, and flags terminal count with a one-cycle pulse. It optionally auto-reloads to produce a periodic tick. It sits beside the up-counters as a generic interval timer and baud/strobe divider for neighbouring blocks.

## Interface
- WIDTH, default 3, counter width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  load strobe; captures load_val into count and into the reload register
- load_val  in  WIDTH  start value (unsigned)
- en  in  1  count enable; ignored in IDLE
- auto_reload  in  1  1 = periodic mode, 0 = one-shot; sampled every cycle
- count  out  WIDTH  current counter value, registered
- busy  out  1  high while the FSM is in RUN, registered
- tc  out  1  terminal-count pulse, registered, one cycle wide

## Operation
- **States**
  - IDLE: count holds; en ignored.
  - RUN: counting.
- **Reset**
  - Reset: state IDLE, count=0, reload_reg=0, busy=0, tc=0. rst overrides every other input.
  - Reset mid-RUN aborts the count. No tc is produced.
- **Priority:** rst > load > en.
- **Load (any state)**
  - load=1 sets count←load_val and reload_reg←load_val. This restarts the timer if it is already running.
  - If load_val≠0: next state RUN, tc=0.
  - If load_val=0: next state IDLE, count=0, tc=1 for one cycle (immediate expiry).
- **RUN, load=0, en=0:** count, state and reload_reg hold; tc=0.
- **RUN, load=0, en=1, count>1:** count←count−1; tc=0.
- **RUN, load=0, en=1, count=1:** count←0; tc=1 on the next cycle.
  - auto_reload=0: next state IDLE, so busy falls on the same edge as count reaching 0.
  - auto_reload=1: stay in RUN.
- **RUN, load=0, en=1, count=0** (reachable only with auto_reload=1):
  - auto_reload=1: count←reload_reg; tc=0.
  - auto_reload=0 at this point: next state IDLE, count holds 0.
- **Period in auto-reload mode:** N+1 enabled cycles for load value N (sequence N…1,0,N…). tc is asserted once per period.
- **Arithmetic**
  - Unsigned, modulo 2^WIDTH.
  - The FSM structure makes count never decrement below 0; no underflow wrap is reachable.
  - WIDTH=3 allows a maximum load of 7.
- **Load in the same cycle as a terminal decrement:** load wins; tc stays 0 on the following cycle.

## Timing
- All outputs are registered; no combinational path from input to output.
- **Load latency:** load sampled at edge k gives count=load_val and busy=1 after edge k. The first decrement occurs at edge k+1 if en=1.
- **tc timing:**
  - tc is high exactly in the cycle following the edge that produced count=0 by decrement or by zero-load.
  - tc deasserts after one cycle regardless of en.
- **One-shot latency:** with en held high, tc occurs N edges after the load edge.
- **auto_reload changes:** a change takes effect on the next edge; it is evaluated only at count=1 and count=0.

## Structure
- **Package downcounter_pkg holds:**
  - the state typedef (IDLE, RUN);
  - the default WIDTH constant (3).
- **Sub-module dffr_vec:** WIDTH-parameterised register with synchronous active-high reset and load enable.
  - Instanced for count and for reload_reg.
  - Matches the family's explicit-flop style.
- **Top level contains:** next-state/next-count dataflow logic, the FSM register, and the tc/busy flops.

## Test plan
1. **Reset:** rst high for 2 cycles during RUN at count=4 → count=0, busy=0, tc=0 after the first reset edge. en and load are ignored while rst=1.
2. **One-shot:** load 5, en=1 held, auto_reload=0 → count 5,4,3,2,1,0 on successive cycles. tc=1 only in the count=0 cycle; busy 1→0 on the same edge; count stays 0 afterwards.
3. **Periodic:** load 2, en=1, auto_reload=1 → count 2,1,0,2,1,0,2…; tc high every third cycle, aligned with count=0; busy stays 1.
4. **Enable gating:** load 3, en pattern 1,0,0,1,1,1 → count 3,2,2,2,1,0; a single tc in the final cycle.
5. **Restart and collision:**
   - load 7 while RUN at count=1 with en=1 → count=7 next, no tc, busy stays 1.
   - Then count 7 down to 0 confirms the max-value range.
6. **Zero load and mode switch:**
   - load 0 → count=0, tc one cycle, busy=0.
   - Separately: periodic run from load 3, with auto_reload cleared while count=0 → next state IDLE, count holds 0, no further tc.
